// File: rtl/conv3x3_window_gen.sv
// 3x3 window generator: loads a filter word, then turns a raster pixel stream into 3x3 windows.
// Optional STRIDE2_EN build emits only windows whose origin row and column are both even.
module conv3x3_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flt_valid,
    input  logic [71:0] flt_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        wb_write_en,
    output logic [71:0] filter,
    output logic [71:0] ifmap,
    output logic        ifmap_valid,
    input  logic        ifmap_ready,
    output logic        frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t         state_q;
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;
    logic           wb_q;
    logic           frame_done_q;
    logic           ifmap_valid_q;
    logic [71:0]    ifmap_q;
    logic [71:0]    filter_q;

    // lb0 holds the previous row, lb1 the row before it, both indexed by column.
    logic [7:0]     lb0_q [IMG_W];
    logic [7:0]     lb1_q [IMG_W];
    logic [23:0]    col_a_q;
    logic [23:0]    col_b_q;

    logic           in_ready_c;
    logic           accept;
    logic           col_last;
    logic           row_last;
    logic           emit;
    logic [23:0]    new_col;
    logic [71:0]    win_d;

    assign in_ready_c = (state_q == RUN) && (!ifmap_valid_q || ifmap_ready);
    assign accept     = in_valid && in_ready_c;
    assign col_last   = (col_q == CW'(IMG_W - 1));
    assign row_last   = (row_q == RW'(IMG_H - 1));
    assign new_col    = {in_data, lb0_q[col_q], lb1_q[col_q]};

`ifdef STRIDE2_EN
    // (row-2) and (col-2) are even exactly when row and col are even.
    assign emit = accept && (row_q >= RW'(2)) && (col_q >= CW'(2)) && !row_q[0] && !col_q[0];
`else
    assign emit = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
`endif

    always_comb begin
        win_d = '0;
        for (int r = 0; r < 3; r++) begin
            win_d[8*(3*r)   +: 8] = col_a_q[8*r +: 8];
            win_d[8*(3*r+1) +: 8] = col_b_q[8*r +: 8];
            win_d[8*(3*r+2) +: 8] = new_col[8*r +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= in_data;
            col_a_q      <= col_b_q;
            col_b_q      <= new_col;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            wb_q          <= 1'b0;
            frame_done_q  <= 1'b0;
            ifmap_valid_q <= 1'b0;
            ifmap_q       <= '0;
            filter_q      <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    col_q <= '0;
                    row_q <= '0;
                    if (flt_valid) begin
                        filter_q <= flt_data;
                        state_q  <= LOAD;
                    end
                end
                // LOAD spends one settle cycle, then one cycle with the write pulse high.
                LOAD: begin
                    if (!wb_q) begin
                        wb_q <= 1'b1;
                    end else begin
                        wb_q    <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (emit) begin
                        ifmap_q       <= win_d;
                        ifmap_valid_q <= 1'b1;
                    end else if (ifmap_ready) begin
                        ifmap_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                            if (row_last) state_q <= DRAIN;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!ifmap_valid_q || ifmap_ready) begin
                        ifmap_valid_q <= 1'b0;
                        frame_done_q  <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_c;
    assign wb_write_en = wb_q;
    assign filter      = filter_q;
    assign ifmap       = ifmap_q;
    assign ifmap_valid = ifmap_valid_q;
    assign frame_done  = frame_done_q;

endmodule
